// File: rtl/sync_frame_tx_pkg.sv
// Shared definitions for the sync-framed serial transmitter and the
// sequence-detector blocks that listen to it.
package sync_frame_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_DEFAULT = 4'b1011;

  // Counter width for a 0..range-1 count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  function automatic logic sync_bit(input logic [3:0] pat, input logic [1:0] idx);
    return pat[2'd3 - idx];
  endfunction

endpackage

// File: rtl/sync_frame_tx_tick.sv
// Bit-period timer: tick marks the last clock of each DIV-cycle bit period.
module tick_gen
  import sync_frame_tx_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: a 4-bit sync header followed by a DW-bit payload,
// MSB first, each bit held for DIV clocks; idle line level is 0.
module sync_frame_tx
  import sync_frame_tx_pkg::*;
#(
  parameter int         DW   = 8,
  parameter logic [3:0] SYNC = SYNC_DEFAULT,
  parameter int         DIV  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] din,
  output logic          tx,
  output logic          busy,
  output logic          done,
  output logic [7:0]    frame_cnt
);

  localparam int BW = cnt_width((DW > 4) ? DW : 4);
  localparam logic [BW-1:0] LAST_SYNC = BW'(3);
  localparam logic [BW-1:0] LAST_DATA = BW'(DW - 1);

  state_t        state, state_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [DW-1:0] sreg, sreg_n;
  logic          tx_n, busy_n, done_n;
  logic [7:0]    cnt_n;
  logic          clr, tick;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      sreg      <= '0;
      tx        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_n;
      sreg      <= sreg_n;
      tx        <= tx_n;
      busy      <= busy_n;
      done      <= done_n;
      frame_cnt <= cnt_n;
    end
  end

  // Outputs are computed one cycle ahead so tx/busy/done come straight from flops.
  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    sreg_n  = sreg;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    cnt_n   = frame_cnt;
    clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_n   = 1'b0;
        busy_n = 1'b0;
        if (start) begin
          clr     = 1'b1;
          sreg_n  = din;
          bit_n   = '0;
          state_n = ST_SYNC;
          tx_n    = SYNC[3];
          busy_n  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (tick) begin
          if (bit_idx == LAST_SYNC) begin
            state_n = ST_DATA;
            bit_n   = '0;
            tx_n    = sreg[DW-1];
            sreg_n  = sreg << 1;
          end else begin
            bit_n = bit_idx + 1'b1;
            tx_n  = sync_bit(SYNC, bit_idx[1:0] + 2'd1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == LAST_DATA) begin
            state_n = ST_IDLE;
            bit_n   = '0;
            tx_n    = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            cnt_n   = frame_cnt + 8'd1;
          end else begin
            bit_n  = bit_idx + 1'b1;
            tx_n   = sreg[DW-1];
            sreg_n = sreg << 1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
